// File: rtl/crc32_pkg.sv
// Shared CRC32-MPEG2 constants, state type and a single-bit LFSR step.
// Used by the receive-side checker and the matching generator.
package crc32_pkg;

  localparam logic [31:0] CRC32_MPEG2_POLY  = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_MPEG2_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_MPEG2_CHECK = 32'h0376_E6E7;
  // Shortest frame that can hold a payload bit plus the 32-bit CRC.
  localparam int          CRC32_MIN_FRAME   = 33;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } crc_state_t;

  // One MSB-first LFSR step with the MPEG2 polynomial.
  function automatic logic [31:0] crc32_step(input logic [31:0] lfsr, input logic din);
    return {lfsr[30:0], 1'b0} ^ (((lfsr[31] ^ din) == 1'b1) ? CRC32_MPEG2_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/crc32_lfsr_step.sv
// Combinational single-bit CRC32 LFSR step (MSB-first, normal polynomial form).
module crc32_lfsr_step #(
  parameter logic [31:0] POLY = 32'h04C1_1DB7
) (
  input  logic [31:0] lfsr_in,
  input  logic        din,
  output logic [31:0] lfsr_out
);

  logic fb;

  // Feedback is the outgoing MSB mixed with the incoming data bit.
  assign fb       = lfsr_in[31] ^ din;
  assign lfsr_out = {lfsr_in[30:0], 1'b0} ^ (fb ? POLY : 32'h0);

endmodule

// File: rtl/crc32_check.sv
// CRC32-MPEG2 receive checker: runs the LFSR over a serial MSB-first frame
// (payload followed by its CRC) and reports pass/fail when the frame ends.
// A correct frame leaves a zero residue.
//
// Interface semantics: axiiv qualifies axiid on every clock; there is no
// ready, the block accepts a bit on every cycle axiiv=1. A frame is one
// contiguous run of axiiv=1. axiov and pay_v are single-cycle qualifiers for
// their data with no backpressure; residue/runt/bit_count/axiod hold their
// value until the next result.
//
// Optional feature: define CRC32_CHECK_STRIP_EN to emit the payload with the
// trailing 32 CRC bits removed on pay_v/pay_d; otherwise both are tied to 0.
module crc32_check
  import crc32_pkg::*;
#(
  parameter logic [31:0] POLY    = CRC32_MPEG2_POLY,
  parameter logic [31:0] INIT    = CRC32_MPEG2_INIT,
  parameter int          COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               axiiv,
  input  logic               axiid,
  output logic               axiov,
  output logic               axiod,
  output logic [31:0]        residue,
  output logic               runt,
  output logic [COUNT_W-1:0] bit_count,
  output logic               pay_v,
  output logic               pay_d
);

  crc_state_t         state, state_n;
  logic [31:0]        lfsr, lfsr_n;
  logic [31:0]        step_in, step_out;
  logic [COUNT_W-1:0] cnt, cnt_n;
  logic               frame_end;
  logic               cnt_runt;

  // The first bit of a frame is stepped from INIT so it is never lost.
  assign step_in = (state == IDLE) ? INIT : lfsr;

  crc32_lfsr_step #(.POLY(POLY)) u_step (
    .lfsr_in  (step_in),
    .din      (axiid),
    .lfsr_out (step_out)
  );

  assign cnt_runt = (cnt < COUNT_W'(CRC32_MIN_FRAME));

  // State, LFSR and frame bit counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      lfsr  <= lfsr_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: start, step, and end-of-frame detection.
  always_comb begin
    state_n   = state;
    lfsr_n    = lfsr;
    cnt_n     = cnt;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (axiiv) begin
          lfsr_n  = step_out;
          cnt_n   = COUNT_W'(1);
          state_n = RUN;
        end
      end
      RUN: begin
        if (axiiv) begin
          lfsr_n = step_out;
          cnt_n  = (cnt == '1) ? cnt : cnt + 1'b1;
        end else begin
          frame_end = 1'b1;
          lfsr_n    = INIT;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        lfsr_n  = INIT;
      end
    endcase
  end

  // Result registers: capture on the first idle cycle after a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axiov     <= 1'b0;
      axiod     <= 1'b0;
      residue   <= '0;
      runt      <= 1'b0;
      bit_count <= '0;
    end else begin
      axiov <= frame_end;
      if (frame_end) begin
        residue   <= lfsr;
        bit_count <= cnt;
        runt      <= cnt_runt;
        axiod     <= (lfsr == 32'h0) && !cnt_runt;
      end
    end
  end

`ifdef CRC32_CHECK_STRIP_EN
  logic [31:0] dly;

  // Payload delay line: once 32 bits are buffered, each new bit releases the
  // oldest one, so the final 32 bits (the CRC) stay behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly   <= '0;
      pay_v <= 1'b0;
      pay_d <= 1'b0;
    end else begin
      pay_v <= 1'b0;
      if (axiiv) begin
        if (state == IDLE) begin
          dly <= {31'b0, axiid};
        end else begin
          dly <= {dly[30:0], axiid};
          if (cnt >= COUNT_W'(32)) begin
            pay_v <= 1'b1;
            pay_d <= dly[31];
          end
        end
      end
    end
  end
`else
  assign pay_v = 1'b0;
  assign pay_d = 1'b0;
`endif

endmodule
